// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
// Turns a valid/ready command stream into single-beat AXI4-Lite reads and
// writes, one transaction outstanding at a time, and returns each read word
// or write response on a valid/ready response stream.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn      clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command stream (ready registered)
//   rsp_valid/ready/rdata/resp/timeout       response stream (fields held)
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*   AXI4-Lite master
//
// Optional feature macro: AXI_CMD_TIMEOUT_EN
//   Adds a per-state watchdog; after TIMEOUT_CYCLES clocks stuck in an AXI
//   phase the transaction is abandoned and answered with SLVERR plus
//   rsp_timeout=1. Without it rsp_timeout is tied low and the block waits.
module axi_lite_cmd_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

    // Elaboration-time parameter sanity checks
    if (C_M_AXI_DATA_WIDTH != 32) begin : g_dw_check
        $error("axi_lite_cmd_master: only 32-bit data is supported");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
        $error("axi_lite_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            cmd_ready_d;
    logic            rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_d;
    logic [1:0]      rsp_resp_d;
    logic            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

`ifdef AXI_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    // Captured command drives both address channels and the write payload
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        awvalid_d   = m_axi_awvalid;
        wvalid_d    = m_axi_wvalid;
        bready_d    = m_axi_bready;
        arvalid_d   = m_axi_arvalid;
        rready_d    = m_axi_rready;
`ifdef AXI_CMD_TIMEOUT_EN
        tmo_cnt_d     = '0;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; leave once both are gone
                if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d     = S_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = S_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d     = S_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_rdata_d = m_axi_rdata;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
            end
        endcase

`ifdef AXI_CMD_TIMEOUT_EN
        // A normal completion clears the timeout flag for the new response
        if (state_d == S_RSP && state_q != S_RSP) rsp_timeout_d = 1'b0;

        // Watchdog: restarts on every state change, fires only if still stuck
        if (state_q inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA}) begin
            if (state_d != state_q) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d       = S_RSP;
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_resp_d    = 2'b10;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b1;
                tmo_cnt_d     = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
        end
    end

`ifdef AXI_CMD_TIMEOUT_EN
    // Watchdog counter and timeout flag
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
